sampled_value_checker: RTL and testbench

- Parametrised multi-channel checker for SystemVerilog sampled-value semantics: $changed, $stable, $rose, $fell and $past(x, DEPTH).
- Each clock, it samples N channels, keeps a DEPTH-deep history and evaluates a selectable property per channel.
- It reports per-channel results, a failure count and a sticky error.
- Used as a synthesisable golden model beside concurrent assertions in feature tests, so tool results can be cross-checked cycle by cycle.

---
 rtl/sampled_value_checker.sv | 109 ++++++++++
 tb/tb_sampled_value_checker.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sampled_value_checker.sv
// rtl/sampled_value_checker.sv - multi-channel golden model of $changed/$stable/$rose/$fell/$past.
// Samples CHANNELS lanes each enabled edge; registers results, fail count and sticky error.
module sampled_value_checker #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 1,
    parameter int DEPTH    = 1,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clr,
    input  logic [2:0]                  mode,
    input  logic [CHANNELS*WIDTH-1:0]   sig_i,
    output logic [CHANNELS-1:0]         changed_o,
    output logic [CHANNELS-1:0]         stable_o,
    output logic [CHANNELS-1:0]         rose_o,
    output logic [CHANNELS-1:0]         fell_o,
    output logic [CHANNELS*WIDTH-1:0]   past_o,
    output logic                        valid_o,
    output logic [CHANNELS-1:0]         fail_o,
    output logic [CNT_W-1:0]            fail_cnt_o,
    output logic                        err_sticky_o
);

    localparam int NW = CHANNELS * WIDTH;
    localparam int FW = $clog2(DEPTH + 1);

    // hist[0] is the previous sample, hist[DEPTH-1] the one DEPTH samples back
    logic [NW-1:0]       hist [DEPTH];
    logic [FW-1:0]       fill;
    logic [FW-1:0]       fill_n;
    logic                valid_n;
    logic [CHANNELS-1:0] chg_n;
    logic [CHANNELS-1:0] rose_n;
    logic [CHANNELS-1:0] fell_n;
    logic [CHANNELS-1:0] peq_n;
    logic [CHANNELS-1:0] prop_n;
    logic [CHANNELS-1:0] fail_n;

    always_comb begin
        fill_n  = (fill == FW'(DEPTH)) ? fill : fill + FW'(1);
        valid_n = (fill_n == FW'(DEPTH));
        chg_n   = '0;
        rose_n  = '0;
        fell_n  = '0;
        peq_n   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            chg_n[c]  = sig_i[c*WIDTH +: WIDTH] != hist[0][c*WIDTH +: WIDTH];
            rose_n[c] = !hist[0][c*WIDTH] && sig_i[c*WIDTH];
            fell_n[c] = hist[0][c*WIDTH] && !sig_i[c*WIDTH];
            peq_n[c]  = sig_i[c*WIDTH +: WIDTH] == hist[DEPTH-1][c*WIDTH +: WIDTH];
        end
        case (mode)
            3'd0:    prop_n = chg_n;
            3'd1:    prop_n = ~chg_n;
            3'd2:    prop_n = rose_n;
            3'd3:    prop_n = fell_n;
            3'd4:    prop_n = peq_n;
            default: prop_n = '1;
        endcase
        fail_n = valid_n ? ~prop_n : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
            fill         <= '0;
            changed_o    <= '0;
            stable_o     <= '0;
            rose_o       <= '0;
            fell_o       <= '0;
            past_o       <= '0;
            valid_o      <= 1'b0;
            fail_o       <= '0;
            fail_cnt_o   <= '0;
            err_sticky_o <= 1'b0;
        end else begin
            fail_o <= '0;
            if (en) begin
                changed_o <= chg_n;
                stable_o  <= ~chg_n;
                rose_o    <= rose_n;
                fell_o    <= fell_n;
                past_o    <= hist[DEPTH-1];
                valid_o   <= valid_n;
                fail_o    <= fail_n;
                fill      <= fill_n;
                hist[0]   <= sig_i;
                for (int i = 1; i < DEPTH; i++) begin
                    hist[i] <= hist[i-1];
                end
            end
            // clear beats a coincident failure
            if (clr) begin
                fail_cnt_o   <= '0;
                err_sticky_o <= 1'b0;
            end else if (en && (|fail_n)) begin
                if (fail_cnt_o != {CNT_W{1'b1}}) begin
                    fail_cnt_o <= fail_cnt_o + CNT_W'(1);
                end
                err_sticky_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sampled_value_checker.sv
// tb/tb_sampled_value_checker.sv - self-checking bench for sampled_value_checker.
// Three configurations share control inputs; a sample-history model predicts every output.
module tb_sampled_value_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic        clr;
    logic [2:0]  mode;
    logic [15:0] sig [3];

    logic [1:0]  a_chg [3];
    logic [1:0]  a_stb [3];
    logic [1:0]  a_rose [3];
    logic [1:0]  a_fell [3];
    logic [1:0]  a_fail [3];
    logic [15:0] a_past [3];
    logic [15:0] a_cnt [3];
    logic        a_valid [3];
    logic        a_stk [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int GW  = (g == 0) ? 1 : (g == 1) ? 4 : 8;
        localparam int GC  = (g == 1) ? 2 : 1;
        localparam int GD  = (g == 2) ? 3 : 1;
        localparam int GCW = (g == 1) ? 3 : 16;
        logic [GC-1:0]    chg, stb, rs, fl, fa;
        logic [GC*GW-1:0] past;
        logic             vld, stk;
        logic [GCW-1:0]   cnt;
        sampled_value_checker #(.WIDTH(GW), .CHANNELS(GC), .DEPTH(GD), .CNT_W(GCW)) u_dut (
            .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
            .sig_i(sig[g][GC*GW-1:0]),
            .changed_o(chg), .stable_o(stb), .rose_o(rs), .fell_o(fl),
            .past_o(past), .valid_o(vld), .fail_o(fa),
            .fail_cnt_o(cnt), .err_sticky_o(stk)
        );
        assign a_chg[g]   = 2'(chg);
        assign a_stb[g]   = 2'(stb);
        assign a_rose[g]  = 2'(rs);
        assign a_fell[g]  = 2'(fl);
        assign a_fail[g]  = 2'(fa);
        assign a_past[g]  = 16'(past);
        assign a_cnt[g]   = 16'(cnt);
        assign a_valid[g] = vld;
        assign a_stk[g]   = stk;
    end

    int checks = 0;
    int errors = 0;

    // model: every sample since reset, indexed by its ordinal
    logic [15:0] smp [3][64];
    int          n [3];
    logic [1:0]  e_chg [3];
    logic [1:0]  e_stb [3];
    logic [1:0]  e_rose [3];
    logic [1:0]  e_fell [3];
    logic [1:0]  e_fail [3];
    logic [15:0] e_past [3];
    int          e_cnt [3];
    logic        e_valid [3];
    logic        e_stk [3];

    function automatic int cfg_w(int g);  return (g == 0) ? 1 : (g == 1) ? 4 : 8; endfunction
    function automatic int cfg_c(int g);  return (g == 1) ? 2 : 1; endfunction
    function automatic int cfg_d(int g);  return (g == 2) ? 3 : 1; endfunction
    function automatic int cfg_cw(int g); return (g == 1) ? 3 : 16; endfunction

    task automatic model_reset();
        for (int g = 0; g < 3; g++) begin
            n[g] = 0;
            e_chg[g] = '0; e_stb[g] = '0; e_rose[g] = '0; e_fell[g] = '0; e_fail[g] = '0;
            e_past[g] = '0; e_cnt[g] = 0; e_valid[g] = 1'b0; e_stk[g] = 1'b0;
        end
    endtask

    task automatic model_step();
        int w, c, d, nw, a, p, o, lim;
        logic [15:0] cur, prv, old;
        bit ok, any;
        for (int g = 0; g < 3; g++) begin
            w = cfg_w(g); c = cfg_c(g); d = cfg_d(g); nw = w * c;
            lim = (1 << cfg_cw(g)) - 1;
            cur = 16'(int'(sig[g]) % (1 << nw));
            any = 1'b0;
            if (en) begin
                prv = (n[g] >= 1) ? smp[g][(n[g] - 1) % 64] : 16'd0;
                old = (n[g] >= d) ? smp[g][(n[g] - d) % 64] : 16'd0;
                e_fail[g] = '0;
                for (int ch = 0; ch < c; ch++) begin
                    a = (int'(cur) >> (ch * w)) % (1 << w);
                    p = (int'(prv) >> (ch * w)) % (1 << w);
                    o = (int'(old) >> (ch * w)) % (1 << w);
                    e_chg[g][ch]  = (a != p);
                    e_stb[g][ch]  = (a == p);
                    e_rose[g][ch] = (p % 2 == 0) && (a % 2 == 1);
                    e_fell[g][ch] = (p % 2 == 1) && (a % 2 == 0);
                    case (mode)
                        3'd0:    ok = (a != p);
                        3'd1:    ok = (a == p);
                        3'd2:    ok = e_rose[g][ch];
                        3'd3:    ok = e_fell[g][ch];
                        3'd4:    ok = (a == o);
                        default: ok = 1'b1;
                    endcase
                    e_fail[g][ch] = (n[g] + 1 >= d) && !ok;
                    any = any | e_fail[g][ch];
                end
                e_past[g]  = old;
                e_valid[g] = (n[g] + 1 >= d);
                smp[g][n[g] % 64] = cur;
                n[g]++;
            end else begin
                e_fail[g] = '0;
            end
            if (clr) begin
                e_cnt[g] = 0;
                e_stk[g] = 1'b0;
            end else if (any) begin
                if (e_cnt[g] < lim) e_cnt[g]++;
                e_stk[g] = 1'b1;
            end
        end
    endtask

    task automatic chk(string nm, int g, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d actual=%h required=%h t=%0t", nm, g, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < 3; g++) begin
            chk("changed", g, 16'(a_chg[g]), 16'(e_chg[g]));
            chk("stable", g, 16'(a_stb[g]), 16'(e_stb[g]));
            chk("rose", g, 16'(a_rose[g]), 16'(e_rose[g]));
            chk("fell", g, 16'(a_fell[g]), 16'(e_fell[g]));
            chk("past", g, a_past[g], e_past[g]);
            chk("valid", g, 16'(a_valid[g]), 16'(e_valid[g]));
            chk("fail", g, 16'(a_fail[g]), 16'(e_fail[g]));
            chk("fail_cnt", g, a_cnt[g], 16'(e_cnt[g]));
            chk("sticky", g, 16'(a_stk[g]), 16'(e_stk[g]));
        end
    endtask

    task automatic cyc();
        if (rst) model_reset(); else model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_valid_now", 2, 16'(a_valid[2]), 16'd0);
        cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       en;
        logic       clr;
        logic [2:0] mode;
        logic       s;
        logic       e_chg;
        logic       e_fail;
        int         e_cnt;
        logic       e_stk;
    } vec_t;

    vec_t tbl [22];

    logic [15:0] past_seq  [6];
    logic [15:0] past_exp  [6];
    logic        valid_exp [6];

    initial begin
        for (int i = 0; i < 12; i++) tbl[i] = '{1'b1, 1'b0, 3'd0, (i % 2 == 0), 1'b1, 1'b0, 0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        for (int i = 0; i < 5; i++) tbl[13 + i] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, i + 1, 1'b1};
        tbl[18] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1, 1'b1};
        tbl[21] = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1, 1'b1};

        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 3'd0;
        for (int g = 0; g < 3; g++) sig[g] = 16'hffff;
        cyc();
        cyc();
        chk("reset_cnt", 0, a_cnt[0], 16'd0);
        chk("reset_valid", 0, 16'(a_valid[0]), 16'd0);
        rst = 1'b0;

        // toggle / hold / clear on the single-bit lane
        for (int i = 0; i < 22; i++) begin
            en = tbl[i].en; clr = tbl[i].clr; mode = tbl[i].mode;
            sig[0] = {15'd0, tbl[i].s};
            sig[1] = 16'($urandom);
            sig[2] = 16'($urandom);
            cyc();
            chk("tbl_changed", i, 16'(a_chg[0]), 16'(tbl[i].e_chg));
            chk("tbl_fail", i, 16'(a_fail[0]), 16'(tbl[i].e_fail));
            chk("tbl_cnt", i, a_cnt[0], 16'(tbl[i].e_cnt));
            chk("tbl_sticky", i, 16'(a_stk[0]), 16'(tbl[i].e_stk));
        end

        // rose/fell on two 4-bit lanes, ch1 held at 0xA
        clr = 1'b0; mode = 3'd2;
        sig[1] = 16'h00a0; cyc();
        sig[1] = 16'h00a0; cyc();
        sig[1] = 16'h00a1; cyc();
        chk("rf_rose_s2", 1, 16'(a_rose[1]), 16'd1);
        chk("rf_fell_s2", 1, 16'(a_fell[1]), 16'd0);
        chk("rf_fail_s2", 1, 16'(a_fail[1]), 16'd2);
        sig[1] = 16'h00a1; cyc();
        chk("rf_rose_s3", 1, 16'(a_rose[1]), 16'd0);
        chk("rf_fail_s3", 1, 16'(a_fail[1]), 16'd3);
        sig[1] = 16'h00a0; cyc();
        chk("rf_fell_s4", 1, 16'(a_fell[1]), 16'd1);
        chk("rf_fail_s4", 1, 16'(a_fail[1]), 16'd3);

        // $past over depth 3 from a fresh history
        async_reset();
        mode = 3'd4;
        past_seq  = '{16'd5, 16'd6, 16'd7, 16'd5, 16'd6, 16'd7};
        past_exp  = '{16'd0, 16'd0, 16'd0, 16'd5, 16'd6, 16'd7};
        valid_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            sig[2] = past_seq[i];
            cyc();
            chk("past_val", i, a_past[2], past_exp[i]);
            chk("past_valid", i, 16'(a_valid[2]), 16'(valid_exp[i]));
            if (i >= 3) chk("past_fail", i, 16'(a_fail[2]), 16'd0);
        end

        // enable low: results hold, fail drops
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 3; g++) sig[g] = 16'($urandom);
            cyc();
            chk("hold_past", i, a_past[2], 16'd7);
            chk("hold_fail", i, 16'(a_fail[0]) | 16'(a_fail[1]) | 16'(a_fail[2]), 16'd0);
        end

        // saturation of the 3-bit counter under STABLE with toggling lanes
        clr = 1'b1; cyc();
        clr = 1'b0; en = 1'b1; mode = 3'd1;
        for (int i = 0; i < 10; i++) begin
            sig[1] = (i % 2 == 0) ? 16'h00ff : 16'h0000;
            cyc();
        end
        chk("sat_cnt", 1, a_cnt[1], 16'd7);
        chk("sat_sticky", 1, 16'(a_stk[1]), 16'd1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 19) == 0);
            mode = 3'($urandom_range(0, 7));
            for (int g = 0; g < 3; g++) begin
                sig[g] = ($urandom_range(0, 2) == 0) ? sig[g] : 16'($urandom);
            end
            if ($urandom_range(0, 49) == 0) async_reset();
            else cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
